// File: rtl/seq_det_sched.sv
// seq_det_sched
//   Round-robin scheduler sharing one external serial "0110" Moore detector
//   between two requesters. A granted frame is latched, the detector is
//   flushed with three '1' bits, the frame is shifted out MSB-first, and the
//   number of detector hits is returned with a one-cycle done pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req[1:0]   request levels, held until the matching gnt bit pulses
//   data0/1    W-bit frames, stable while requesting
//   gnt[1:0]   one-hot grant pulse in the first FLUSH cycle
//   busy       high from the gnt cycle through the done cycle
//   det_in     serial bit to the detector
//   det_out    detector output (Moore, one cycle after the 4th pattern bit)
//   done       one-cycle result pulse
//   done_id    requester served (held until the next done)
//   match_cnt  detector hits in the frame (held until the next done)
module seq_det_sched #(
    parameter int W  = 8,
    parameter int CW = $clog2(W+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [W-1:0]  data0,
    input  logic [W-1:0]  data1,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic          det_in,
    input  logic          det_out,
    output logic          done,
    output logic          done_id,
    output logic [CW-1:0] match_cnt
);

    localparam int PW = $clog2(W);

    typedef enum logic [2:0] {IDLE, FLUSH, SHIFT, DRAIN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  sh;        // frame, MSB is the next bit to send
    logic [CW-1:0] cnt;       // running hit count
    logic [PW-1:0] ph;        // cycle index within FLUSH / SHIFT
    logic          cur_id;    // requester being served
    logic          last_id;   // requester served last; reset to 1 so a first tie goes to 0
    logic          pick;

    // Single request wins outright; a tie goes to whoever was not served last.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_id;
            default: pick = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            det_in    <= 1'b1;
            done      <= 1'b0;
            done_id   <= 1'b0;
            match_cnt <= '0;
            last_id   <= 1'b1;
            cur_id    <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
            ph        <= '0;
        end else begin
            gnt  <= 2'b00;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    det_in <= 1'b1;
                    if (|req) begin
                        state   <= FLUSH;
                        gnt     <= pick ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        cur_id  <= pick;
                        last_id <= pick;
                        sh      <= pick ? data1 : data0;
                        cnt     <= '0;
                        ph      <= '0;
                    end
                end
                FLUSH: begin
                    // det_in stays 1 for the three flush cycles; on the last
                    // one preload the first frame bit for SHIFT cycle 0.
                    ph <= ph + PW'(1);
                    if (ph == PW'(2)) begin
                        state  <= SHIFT;
                        ph     <= '0;
                        det_in <= sh[W-1];
                        sh     <= {sh[W-2:0], 1'b0};
                    end
                end
                SHIFT: begin
                    cnt <= cnt + CW'(det_out);
                    ph  <= ph + PW'(1);
                    if (ph == PW'(W-1)) begin
                        state  <= DRAIN;
                        det_in <= 1'b1;
                    end else begin
                        det_in <= sh[W-1];
                        sh     <= {sh[W-2:0], 1'b0};
                    end
                end
                DRAIN: begin
                    // This sample catches a match completed by the last frame bit.
                    cnt       <= cnt + CW'(det_out);
                    match_cnt <= cnt + CW'(det_out);
                    done_id   <= cur_id;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboarded random bench for seq_det_sched with a behavioural detector.
module tb_seq_det_sched;
    localparam int W  = 8;
    localparam int CW = $clog2(W+1);

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [W-1:0]  data0, data1;
    logic [1:0]    gnt;
    logic          busy, det_in, det_out, done, done_id;
    logic [CW-1:0] match_cnt;

    // External detector: remembers the last four bits it was clocked.
    logic       ovr = 1'b0, ovr_bit = 1'b0;
    logic [3:0] hist = 4'b1111;
    always @(posedge clk) hist <= {hist[2:0], ovr ? ovr_bit : det_in};
    assign det_out = (hist == 4'b0110);

    seq_det_sched #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .busy(busy), .det_in(det_in), .det_out(det_out),
        .done(done), .done_id(done_id), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Overlapping occurrences of 0110 in the frame read MSB-first.
    function automatic int ref_count(input logic [W-1:0] d);
        int n = 0;
        for (int i = 0; i <= W-4; i++)
            if (d[i+3 -: 4] == 4'b0110) n++;
        return n;
    endfunction

    typedef struct { logic id; int cnt; } exp_t;
    exp_t sbq[$];

    // Cycle-level model: W+5 busy cycles per frame, grant in the first.
    int       m_left = 0;
    logic     m_last = 1'b1;
    logic [1:0] m_gnt = 2'b00;
    always @(negedge clk) begin
        logic id;
        exp_t e;
        if (rst) begin
            m_left = 0; m_last = 1'b1; sbq.delete();
            chk("rst_gnt", gnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_det_in", det_in, 1);
            chk("rst_done", done, 0);
            chk("rst_done_id", done_id, 0);
            chk("rst_match_cnt", match_cnt, 0);
        end else begin
            chk("gnt", gnt, (m_left == W+5) ? m_gnt : 2'b00);
            chk("busy", busy, m_left > 0);
            chk("done", done, m_left == 1);
            if (m_left == 0) chk("idle_det_in", det_in, 1);
            if (m_left > 0) m_left--;
            else if (req != 2'b00) begin
                id = (req == 2'b01) ? 1'b0 : (req == 2'b10) ? 1'b1 : !m_last;
                m_last = id;
                m_gnt  = id ? 2'b10 : 2'b01;
                m_left = W+5;
                e.id  = id;
                e.cnt = ref_count(id ? data1 : data0);
                sbq.push_back(e);
            end
        end
    end

    // Monitor: pop the oldest expected result on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done got=done expected=none at %0t", $time);
            end else begin
                e = sbq.pop_front();
                chk("done_id", done_id, e.id);
                chk("match_cnt", match_cnt, e.cnt);
            end
        end
    end

    // Raise requests, drop each req bit 'hold' cycles after its grant,
    // and wait until every expected result has been consumed.
    task automatic serve(input logic [1:0] r, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input int hold);
        int cyc = 0, hc0 = 0, hc1 = 0;
        data0 = d0; data1 = d1; req = r;
        while ((req != 2'b00 || sbq.size() != 0) && cyc < 400) begin
            @(posedge clk); #1; cyc++;
            ovr = 1'b0;
            if (hc0 > 0) begin hc0--; if (hc0 == 0) begin req[0] = 1'b0; data0 = W'($urandom); end end
            if (hc1 > 0) begin hc1--; if (hc1 == 0) begin req[1] = 1'b0; data1 = W'($urandom); end end
            if (gnt[0]) hc0 = hold;
            if (gnt[1]) hc1 = hold;
        end
        if (cyc >= 400) begin
            checks++; errors++;
            $display("FAIL serve_timeout got=pending expected=complete at %0t", $time);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Ties right after reset: 0 then 1, and again 0 then 1.
        serve(2'b11, 8'b01101100, 8'b00000110, 1);
        serve(2'b11, 8'hFF, 8'b01101100, 1);

        // Directed frames.
        serve(2'b01, 8'b01101100, '0, 1);
        serve(2'b01, 8'b00000110, '0, 1);
        serve(2'b01, 8'hFF, '0, 1);
        serve(2'b10, '0, 8'b01100110, 1);

        // Stale detector history 0,1,1 right up to the sampled request.
        @(posedge clk); #1 ovr = 1'b1; ovr_bit = 1'b0;
        @(posedge clk); #1 ovr_bit = 1'b1;
        @(posedge clk); #1 ovr_bit = 1'b1;
        serve(2'b01, 8'b01000000, '0, 1);

        // Request dropped two cycles after the grant.
        serve(2'b01, 8'b00110110, '0, 2);

        // Reset during SHIFT cycle 3.
        data0 = 8'b01101101; req = 2'b01; cyc = 0;
        while (gnt[0] !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        if (cyc >= 20) begin
            checks++; errors++;
            $display("FAIL abort_gnt_timeout got=no_gnt expected=gnt at %0t", $time);
        end
        req = 2'b00;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_gnt", gnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_det_in", det_in, 1);
        chk("abort_done", done, 0);
        chk("abort_match_cnt", match_cnt, 0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        repeat (W+8) @(posedge clk);
        #1;
        serve(2'b01, 8'b01101100, '0, 1);

        // Random traffic.
        for (int i = 0; i < 40; i++)
            serve(2'($urandom_range(1, 3)), W'($urandom), W'($urandom), $urandom_range(1, 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
